// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO controller driving both ports of an external two-port RAM.
// Tracks occupancy, raises full/empty/almost flags, and latches sticky misuse errors.
module ram_fifo_ctrl #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_Wr_DV,
    input  logic [WIDTH-1:0]         i_Wr_Data,
    output logic                     o_Full,
    output logic                     o_AF,
    input  logic                     i_Rd_En,
    output logic                     o_Rd_DV,
    output logic [WIDTH-1:0]         o_Rd_Data,
    output logic                     o_Empty,
    output logic                     o_AE,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Ovf,
    output logic                     o_Unf,
    output logic [$clog2(DEPTH)-1:0] o_Ram_Wr_Addr,
    output logic                     o_Ram_Wr_DV,
    output logic [WIDTH-1:0]         o_Ram_Wr_Data,
    output logic [$clog2(DEPTH)-1:0] o_Ram_Rd_Addr,
    output logic                     o_Ram_Rd_En,
    input  logic                     i_Ram_Rd_DV,
    input  logic [WIDTH-1:0]         i_Ram_Rd_Data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] next_count;
    logic          wr_ok;
    logic          rd_ok;
    logic          rd_pend;

    // Accept decisions use the registered flags, so a same-cycle opposite
    // operation never rescues a write at full or a read at empty.
    assign wr_ok = i_Wr_DV & ~o_Full;
    assign rd_ok = i_Rd_En & ~o_Empty;

    assign o_Ram_Wr_DV   = wr_ok;
    assign o_Ram_Wr_Addr = wr_ptr;
    assign o_Ram_Wr_Data = i_Wr_Data;
    assign o_Ram_Rd_En   = rd_ok;
    assign o_Ram_Rd_Addr = rd_ptr;

    always_comb begin
        // NOTE: default assignment first so every path drives next_count and no latch is inferred.
        next_count = o_Count;
        case ({wr_ok, rd_ok})
            2'b10:   next_count = o_Count + CW'(1);
            2'b01:   next_count = o_Count - CW'(1);
            default: next_count = o_Count;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_Count <= '0;
            o_Full  <= 1'b0;
            o_Empty <= 1'b1;
            o_AF    <= 1'b0;
            o_AE    <= 1'b1;
            o_Ovf   <= 1'b0;
            o_Unf   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            o_Count <= next_count;
            o_Full  <= (next_count == FULL_CNT);
            o_Empty <= (next_count == '0);
            o_AF    <= (next_count >= AF_CNT);
            o_AE    <= (next_count <= AE_CNT);
            if (i_Wr_DV & o_Full)  o_Ovf <= 1'b1;
            if (i_Rd_En & o_Empty) o_Unf <= 1'b1;
        end
    end

    // rd_pend qualifies the RAM return so data launched before a reset is dropped.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            rd_pend   <= 1'b0;
            o_Rd_DV   <= 1'b0;
            o_Rd_Data <= '0;
        end else begin
            rd_pend <= rd_ok;
            o_Rd_DV <= i_Ram_Rd_DV & rd_pend;
            if (i_Ram_Rd_DV & rd_pend) o_Rd_Data <= i_Ram_Rd_Data;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl at DEPTH=4 with a behavioural two-port RAM
// whose read return is registered one cycle after the read enable.
module tb_ram_fifo_ctrl;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_dv = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_en = 1'b0;
    logic             full, af, empty, ae, ovf, unf, rd_dv;
    logic [WIDTH-1:0] rd_data;
    logic [2:0]       count;
    logic [1:0]       ram_wr_addr, ram_rd_addr;
    logic             ram_wr_dv, ram_rd_en;
    logic [WIDTH-1:0] ram_wr_data;
    logic             ram_rd_dv = 1'b0;
    logic [WIDTH-1:0] ram_rd_data = '0;
    logic [WIDTH-1:0] mem [DEPTH];

    int n_pass  = 0;
    int n_total = 0;

    ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .i_Clk(clk), .i_Rst(rst),
        .i_Wr_DV(wr_dv), .i_Wr_Data(wr_data), .o_Full(full), .o_AF(af),
        .i_Rd_En(rd_en), .o_Rd_DV(rd_dv), .o_Rd_Data(rd_data),
        .o_Empty(empty), .o_AE(ae), .o_Count(count), .o_Ovf(ovf), .o_Unf(unf),
        .o_Ram_Wr_Addr(ram_wr_addr), .o_Ram_Wr_DV(ram_wr_dv), .o_Ram_Wr_Data(ram_wr_data),
        .o_Ram_Rd_Addr(ram_rd_addr), .o_Ram_Rd_En(ram_rd_en),
        .i_Ram_Rd_DV(ram_rd_dv), .i_Ram_Rd_Data(ram_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_dv) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
        ram_rd_dv <= ram_rd_en;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({empty, ae, full, af, ovf, unf, rd_dv} !== 7'b1100000)
            $display("FAIL reset_flags: got %b expected 1100000", {empty, ae, full, af, ovf, unf, rd_dv});
        else n_pass++;
        n_total++;
        if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count);
        else n_pass++;
        n_total++;
        if (rd_data !== 16'h0) $display("FAIL reset_rd_data: got %0h expected 0", rd_data);
        else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_fill();
        logic [WIDTH-1:0] tbl [4];
        tbl = '{16'hA1, 16'hB2, 16'hC3, 16'hD4};
        for (int i = 0; i < 4; i++) begin
            wr_dv   = 1'b1;
            wr_data = tbl[i];
            #1;
            n_total++;
            if ({ram_wr_dv, ram_wr_addr, ram_wr_data} !== {1'b1, 2'(i), tbl[i]})
                $display("FAIL fill_ram_wr[%0d]: got dv=%b addr=%0d data=%0h expected dv=1 addr=%0d data=%0h",
                         i, ram_wr_dv, ram_wr_addr, ram_wr_data, i, tbl[i]);
            else n_pass++;
            step();
            n_total++;
            if (count !== 3'(i + 1)) $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1);
            else n_pass++;
            n_total++;
            if ({af, full, empty, ae} !== {(i >= 2), (i == 3), 1'b0, (i == 0)})
                $display("FAIL fill_flags[%0d]: got af,full,empty,ae=%b expected %b", i,
                         {af, full, empty, ae}, {(i >= 2), (i == 3), 1'b0, (i == 0)});
            else n_pass++;
        end
        wr_dv = 1'b0;
    endtask

    task automatic test_overflow();
        wr_dv   = 1'b1;
        wr_data = 16'hEE;
        #1;
        n_total++;
        if (ram_wr_dv !== 1'b0) $display("FAIL ovf_ram_wr_dv: got %b expected 0", ram_wr_dv);
        else n_pass++;
        step();
        wr_dv = 1'b0;
        n_total++;
        if ({count, full, ovf} !== {3'd4, 1'b1, 1'b1})
            $display("FAIL ovf_state: got count=%0d full=%b ovf=%b expected 4 1 1", count, full, ovf);
        else n_pass++;
        step();
        n_total++;
        if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", ovf);
        else n_pass++;
    endtask

    task automatic test_read_burst();
        logic [WIDTH-1:0] tbl [4];
        tbl = '{16'hA1, 16'hB2, 16'hC3, 16'hD4};
        for (int c = 0; c < 7; c++) begin
            rd_en = (c < 4);
            #1;
            if (c < 4) begin
                n_total++;
                if ({ram_rd_en, ram_rd_addr} !== {1'b1, 2'(c)})
                    $display("FAIL burst_ram_rd[%0d]: got en=%b addr=%0d expected en=1 addr=%0d",
                             c, ram_rd_en, ram_rd_addr, c);
                else n_pass++;
            end
            step();
            n_total++;
            if (rd_dv !== (c >= 1 && c <= 4))
                $display("FAIL burst_rd_dv[%0d]: got %b expected %b", c, rd_dv, (c >= 1 && c <= 4));
            else n_pass++;
            if (c >= 1 && c <= 4) begin
                n_total++;
                if (rd_data !== tbl[c-1])
                    $display("FAIL burst_rd_data[%0d]: got %0h expected %0h", c, rd_data, tbl[c-1]);
                else n_pass++;
            end
        end
        rd_en = 1'b0;
        n_total++;
        if ({empty, count, rd_data, unf} !== {1'b1, 3'd0, 16'hD4, 1'b0})
            $display("FAIL burst_end: got empty=%b count=%0d rd_data=%0h unf=%b expected 1 0 d4 0",
                     empty, count, rd_data, unf);
        else n_pass++;
    endtask

    task automatic test_underflow();
        rd_en   = 1'b1;
        wr_dv   = 1'b1;
        wr_data = 16'h55;
        #1;
        n_total++;
        if ({ram_rd_en, ram_wr_dv, ram_wr_addr} !== {1'b0, 1'b1, 2'd0})
            $display("FAIL unf_ram: got rd_en=%b wr_dv=%b wr_addr=%0d expected 0 1 0",
                     ram_rd_en, ram_wr_dv, ram_wr_addr);
        else n_pass++;
        step();
        rd_en = 1'b0;
        wr_dv = 1'b0;
        n_total++;
        if ({count, unf, empty} !== {3'd1, 1'b1, 1'b0})
            $display("FAIL unf_state: got count=%0d unf=%b empty=%b expected 1 1 0", count, unf, empty);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (rd_dv !== 1'b0) $display("FAIL unf_no_rd_dv[%0d]: got %b expected 0", k, rd_dv);
            else n_pass++;
            step();
        end
        rd_en = 1'b1;
        #1;
        n_total++;
        if ({ram_rd_en, ram_rd_addr} !== {1'b1, 2'd0})
            $display("FAIL unf_readback_addr: got en=%b addr=%0d expected 1 0", ram_rd_en, ram_rd_addr);
        else n_pass++;
        step();
        rd_en = 1'b0;
        step();
        n_total++;
        if ({rd_dv, rd_data} !== {1'b1, 16'h55})
            $display("FAIL unf_readback: got dv=%b data=%0h expected 1 55", rd_dv, rd_data);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] got [$];
        for (int i = 0; i < 14; i++) begin
            wr_dv   = (i < 10);
            wr_data = 16'(i);
            rd_en   = (i >= 1 && i <= 10);
            #1;
            if (i < 10) begin
                n_total++;
                if ({ram_wr_dv, ram_wr_addr} !== {1'b1, 2'(i + 1)})
                    $display("FAIL wrap_wr_addr[%0d]: got dv=%b addr=%0d expected 1 %0d",
                             i, ram_wr_dv, ram_wr_addr, (i + 1) % 4);
                else n_pass++;
            end
            if (i >= 1 && i <= 10) begin
                n_total++;
                if ({ram_rd_en, ram_rd_addr} !== {1'b1, 2'(i)})
                    $display("FAIL wrap_rd_addr[%0d]: got en=%b addr=%0d expected 1 %0d",
                             i, ram_rd_en, ram_rd_addr, i % 4);
                else n_pass++;
            end
            step();
            if (rd_dv) got.push_back(rd_data);
            if (i < 10) begin
                n_total++;
                if (count !== 3'd1) $display("FAIL wrap_count[%0d]: got %0d expected 1", i, count);
                else n_pass++;
            end
        end
        wr_dv = 1'b0;
        rd_en = 1'b0;
        n_total++;
        if (got.size() !== 10) $display("FAIL wrap_n_reads: got %0d expected 10", got.size());
        else n_pass++;
        for (int k = 0; k < got.size() && k < 10; k++) begin
            n_total++;
            if (got[k] !== 16'(k)) $display("FAIL wrap_data[%0d]: got %0h expected %0h", k, got[k], k);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] got [$];
        int first = -1;
        int last  = -1;
        for (int i = 0; i < 13; i++) begin
            wr_dv   = (i < 8);
            wr_data = 16'h30 + 16'(i);
            rd_en   = (i >= 2 && i < 10);
            #1;
            if (i >= 2 && i < 8) begin
                n_total++;
                if (!(ram_wr_dv && ram_rd_en && ram_rd_addr != ram_wr_addr))
                    $display("FAIL b2b_ports[%0d]: got wr_dv=%b rd_en=%b wr_addr=%0d rd_addr=%0d expected both enabled, addresses distinct",
                             i, ram_wr_dv, ram_rd_en, ram_wr_addr, ram_rd_addr);
                else n_pass++;
            end
            step();
            if (rd_dv) begin
                got.push_back(rd_data);
                if (first < 0) first = i;
                last = i;
            end
            if (i >= 1 && i < 8) begin
                n_total++;
                if ({count, af, ae} !== {3'd2, 1'b0, 1'b0})
                    $display("FAIL b2b_count[%0d]: got count=%0d af=%b ae=%b expected 2 0 0", i, count, af, ae);
                else n_pass++;
            end
        end
        wr_dv = 1'b0;
        rd_en = 1'b0;
        n_total++;
        if (got.size() !== 8 || first !== 3 || last !== 10)
            $display("FAIL b2b_stream: got n=%0d first=%0d last=%0d expected 8 3 10", got.size(), first, last);
        else n_pass++;
        for (int k = 0; k < got.size() && k < 8; k++) begin
            n_total++;
            if (got[k] !== 16'h30 + 16'(k))
                $display("FAIL b2b_data[%0d]: got %0h expected %0h", k, got[k], 16'h30 + 16'(k));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        wr_dv   = 1'b1;
        wr_data = 16'h77;
        step();
        wr_dv = 1'b0;
        rd_en = 1'b1;
        #1;
        n_total++;
        if (ram_rd_en !== 1'b1) $display("FAIL rstmid_rd_issue: got %b expected 1", ram_rd_en);
        else n_pass++;
        step();
        rd_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({empty, ae, full, af, ovf, unf, rd_dv} !== 7'b1100000)
            $display("FAIL rstmid_flags: got %b expected 1100000", {empty, ae, full, af, ovf, unf, rd_dv});
        else n_pass++;
        n_total++;
        if ({count, rd_data} !== {3'd0, 16'h0})
            $display("FAIL rstmid_count_data: got count=%0d data=%0h expected 0 0", count, rd_data);
        else n_pass++;
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_total++;
            if ({rd_dv, rd_data, count} !== {1'b0, 16'h0, 3'd0})
                $display("FAIL rstmid_after[%0d]: got dv=%b data=%0h count=%0d expected 0 0 0",
                         k, rd_dv, rd_data, count);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_read_burst();
        test_underflow();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
